// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
//   state_t          controller FSM state (OFF / ARM / RUN / ERR)
//   ASCII_LF/CR      line-control characters
//   DEFAULT_DEPTH    default byte FIFO depth
//   DEFAULT_TIMEOUT  default idle cycles before a partial-line flush
package uart_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2,
    ERR = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int DEFAULT_DEPTH   = 16;
  localparam int DEFAULT_TIMEOUT = 100000;
  localparam int TMO_W           = 24;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver handshake and FIFO read bus of uart_rx_ctrl.
//   rx_en     enable to the 8N1 receiver
//   rx_ready  receiver byte-valid level
//   rx_data   receiver byte
//   rd_en     pop the FIFO head
//   rd_data   FIFO head byte (show-ahead)
//   empty     FIFO empty
//   count     FIFO occupancy
// slave modport is the controller side, master is the receiver/host side.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);
  logic                     rx_en;
  logic                     rx_ready;
  logic [7:0]               rx_data;
  logic                     rd_en;
  logic [7:0]               rd_data;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    output rx_en,
    input  rx_ready,
    input  rx_data,
    input  rd_en,
    output rd_data,
    output empty,
    output count
  );

  modport master (
    input  rx_en,
    output rx_ready,
    output rx_data,
    output rd_en,
    input  rd_data,
    input  empty,
    input  count
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous show-ahead byte FIFO.
//   clk, rst_n  clock, async active-low reset
//   wr_en       push wr_data (ignored when full unless rd_en pops the same cycle)
//   wr_data     byte to push
//   rd_en       pop the head (ignored when empty)
//   rd_data     head byte, valid whenever empty=0
//   empty/full  occupancy flags
//   count       occupancy, 0..DEPTH
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // A pop frees the slot the same edge, so a push into a full FIFO is legal then.
  assign w_push = wr_en && (!full || rd_en);
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory is reset so the head reads 0x00 out of reset; with an empty FIFO the
  // read pointer is frozen, so rd_data holds.
  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign count   = r_count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences an 8N1 receiver, buffers bytes in a FIFO, flags
// end-of-line / idle-timeout flushes and sticky overflow.
//   clk, rst_n  clock, async active-low reset
//   en          enable reception
//   clr_ovf     clear overflow (and leave ERR)
//   line_done   one-cycle pulse: LF written or idle timeout
//   overflow    sticky, a byte was dropped
//   bus         uart_rx_ctrl_if.slave: rx_en/rx_ready/rx_data, rd_en/rd_data/empty/count
// Optional macro UART_RX_CTRL_ECHO_EN adds tx_start/tx_data/tx_busy echo ports.
//
// state | meaning
// OFF   | receiver disabled, edge detector cleared
// ARM   | receiver enabled, edge detector primed with current rx_ready
// RUN   | bytes accepted on rx_ready rising edges
// ERR   | overflow seen, bytes discarded until clr_ovf
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_ovf,
  output logic       line_done,
  output logic       overflow,
`ifdef UART_RX_CTRL_ECHO_EN
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
`endif
  uart_rx_ctrl_if.slave bus
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_rx_en;
  logic             r_prev_ready;
  logic             r_wr_pend;
  logic [7:0]       r_wr_data;
  logic             r_ovf;
  logic [TMO_W-1:0] r_tmo;
  logic             r_tmo_arm;
  logic             w_full;
  logic             w_accept;
  logic             w_drop;
  logic             w_line_done;

  assign w_accept    = (r_state == RUN) && bus.rx_ready && !r_prev_ready;
  // Fullness is judged when the byte is accepted; the write lands a cycle later.
  assign w_drop      = w_accept && w_full && !bus.rd_en;
  // The timer only flushes once per idle period: it is armed by a byte and
  // disarmed by any line_done.
  assign w_line_done = (r_wr_pend && (r_wr_data == ASCII_LF)) ||
                       (r_tmo_arm && (bus.count != '0) && (r_tmo == TMO_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_en     = 1'b0;
    case (r_state)
      OFF: if (en) w_state_nxt = ARM;
      ARM: begin
        w_rx_en     = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_rx_en = 1'b1;
        if (w_drop) w_state_nxt = ERR;
      end
      ERR: begin
        w_rx_en = 1'b1;
        if (clr_ovf) w_state_nxt = RUN;
      end
      default: w_state_nxt = OFF;
    endcase
    if (!en) w_state_nxt = OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_ready <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_wr_data    <= '0;
      r_ovf        <= 1'b0;
    end else begin
      // ARM loads the current level so a stale rx_ready is not a new frame.
      if (!en || (r_state == OFF)) r_prev_ready <= 1'b0;
      else                         r_prev_ready <= bus.rx_ready;
      r_wr_pend <= w_accept && !w_drop;
      if (w_accept) r_wr_data <= bus.rx_data;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo     <= '0;
      r_tmo_arm <= 1'b0;
    end else if (w_accept) begin
      r_tmo     <= '0;
      r_tmo_arm <= 1'b1;
    end else if (w_line_done) begin
      r_tmo     <= '0;
      r_tmo_arm <= 1'b0;
    end else if (r_tmo_arm && (bus.count != '0)) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

`ifdef UART_RX_CTRL_ECHO_EN
  logic       r_tx_start;
  logic [7:0] r_tx_data;

  // A busy transmitter simply skips the echo; nothing is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= w_accept && !tx_busy;
      if (w_accept && !tx_busy) r_tx_data <= bus.rx_data;
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
`endif

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_wr_pend),
    .wr_data (r_wr_data),
    .rd_en   (bus.rd_en),
    .rd_data (bus.rd_data),
    .empty   (bus.empty),
    .full    (w_full),
    .count   (bus.count)
  );

  assign bus.rx_en = w_rx_en;
  assign line_done = w_line_done;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic clr_ovf;
  logic line_done;
  logic overflow;
`ifdef UART_RX_CTRL_ECHO_EN
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
`endif

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_ovf   (clr_ovf),
    .line_done (line_done),
    .overflow  (overflow),
`ifdef UART_RX_CTRL_ECHO_EN
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: FIFO contents, sticky overflow, discarding-after-overflow
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_err = 0;

  logic       last_ld;
  logic [31:0] last_cnt_w;

  int ld_cnt = 0;
  always @(negedge clk) if (line_done === 1'b1) ld_cnt++;

`ifdef UART_RX_CTRL_ECHO_EN
  int         tx_cnt = 0;
  logic [7:0] tx_last = '0;
  always @(negedge clk) if (tx_start === 1'b1) begin
    tx_cnt++;
    tx_last = tx_data;
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    if (q.size() > 0) check({tag, ".head"}, 32'(bus.rd_data), 32'(q[0]));
  endtask

  // One frame: rx_ready rises for one cycle, optionally with a coincident pop.
  task automatic send(input logic [7:0] b, input bit pop_same);
    bit full_now = (q.size() == DEPTH);
    bit push = 0;
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    bus.rd_en    = pop_same;
    if (!m_err) begin
      if (full_now && !pop_same) begin
        m_ovf = 1;
        m_err = 1;
      end else push = 1;
    end
    if (pop_same && q.size() > 0) void'(q.pop_front());
    if (push) q.push_back(b);
    tick();
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    last_ld    = line_done;
    last_cnt_w = 32'(bus.count);
    tick();
    tick();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_ovf();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    m_ovf = 0;
    m_err = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH && q.size() > 0; i++) begin
      check(tag, 32'(bus.rd_data), 32'(q[0]));
      pop();
    end
    check({tag, ".empty"}, 32'(bus.empty), 32'd1);
  endtask

  initial begin
    int ld0, first_hit, hits;
    logic [7:0] hold;

    rst_n = 1'b1;
    en = 1'b0;
    clr_ovf = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rd_en    = 1'b0;
`ifdef UART_RX_CTRL_ECHO_EN
    tx_busy = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("rst.rx_en", 32'(bus.rx_en), 32'd0);
    check("rst.count", 32'(bus.count), 32'd0);
    check("rst.empty", 32'(bus.empty), 32'd1);
    check("rst.rd_data", 32'(bus.rd_data), 32'h00);
    check("rst.line_done", 32'(line_done), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("off.rx_en", 32'(bus.rx_en), 32'd0);

    // arm and run
    en = 1'b1;
    tick();
    check("arm.rx_en", 32'(bus.rx_en), 32'd1);
    tick();
    check("run.rx_en", 32'(bus.rx_en), 32'd1);

    // 0x41 0x42 0x0A line
    ld0 = ld_cnt;
    send(8'h41, 0);
    check("line.cnt_at_write", last_cnt_w, 32'd0);
    check("line.cnt_after1", 32'(bus.count), 32'd1);
    send(8'h42, 0);
    check("line.ld_42", 32'(last_ld), 32'd0);
    send(8'h0A, 0);
    check("line.ld_lf", 32'(last_ld), 32'd1);
    check("line.count", 32'(bus.count), 32'd3);
    check("line.ld_pulses", 32'(ld_cnt - ld0), 32'd1);
    check("line.rd0", 32'(bus.rd_data), 32'h41);
    pop();
    check("line.rd1", 32'(bus.rd_data), 32'h42);
    pop();
    check("line.rd2", 32'(bus.rd_data), 32'h0A);
    pop();
    check_model("line.end");

    // pop while empty is ignored
    hold = bus.rd_data;
    pop();
    check("empty_pop.rd_data", 32'(bus.rd_data), 32'(hold));
    check("empty_pop.count", 32'(bus.count), 32'd0);

    // CR stored without a pulse
    send(8'h0D, 0);
    check("cr.ld", 32'(last_ld), 32'd0);
    drain("cr.drain");

    // idle timeout flush: exactly TIMEOUT cycles after the write, once
    bus.rx_data  = 8'h55;
    bus.rx_ready = 1'b1;
    q.push_back(8'h55);
    tick();
    bus.rx_ready = 1'b0;
    first_hit = -1;
    hits = 0;
    for (int j = 1; j <= 3 * TIMEOUT; j++) begin
      tick();
      if (line_done === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = j;
      end
    end
    check("tmo.first", 32'(first_hit), 32'(TIMEOUT));
    check("tmo.hits", 32'(hits), 32'd1);
    check_model("tmo.fifo");
    drain("tmo.drain");

    // overflow: four stored, fifth dropped, ERR discards, clr_ovf resumes
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    check_model("ovf.full");
    send(8'h05, 0);
    check_model("ovf.drop");
    send(8'h06, 0);
    check_model("ovf.err_discard");
    pop();
    check_model("ovf.err_pop");
    clear_ovf();
    check("ovf.cleared", 32'(overflow), 32'd0);
    send(8'h07, 0);
    check_model("ovf.resume");

    // full FIFO with coincident pop: count stays, new byte at tail
    send(8'h08, 1);
    check("fullpop.count", 32'(bus.count), 32'(DEPTH));
    check("fullpop.head", 32'(bus.rd_data), 32'h03);
    check("fullpop.ovf", 32'(overflow), 32'd0);
    drain("fullpop.drain");

    // rx_ready held high across en toggle
    bus.rx_data  = 8'h61;
    bus.rx_ready = 1'b1;
    q.push_back(8'h61);
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    check("entog.off_rx_en", 32'(bus.rx_en), 32'd0);
    tick();
    bus.rx_data = 8'h62;
    en = 1'b1;
    repeat (4) tick();
    check_model("entog.stale");
    bus.rx_ready = 1'b0;
    tick();
    send(8'h63, 0);
    check_model("entog.new");
    drain("entog.drain");

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) pop();
      else send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      check_model($sformatf("rnd%0d", it));
      if (m_err && ($urandom_range(0, 1) == 1)) clear_ovf();
    end
    if (m_ovf) clear_ovf();
    drain("rnd.drain");

    // overflow kept across en toggle, then async reset mid-RUN with count=2
    for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 0);
    pop();
    pop();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
    m_err = 0;
    check_model("rstmid.pre");
    rst_n = 1'b0;
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h77;
    #2;
    check("rstmid.rx_en", 32'(bus.rx_en), 32'd0);
    check("rstmid.count", 32'(bus.count), 32'd0);
    check("rstmid.empty", 32'(bus.empty), 32'd1);
    check("rstmid.rd_data", 32'(bus.rd_data), 32'h00);
    check("rstmid.line_done", 32'(line_done), 32'd0);
    check("rstmid.ovf", 32'(overflow), 32'd0);
    q.delete();
    m_ovf = 0;
    m_err = 0;
    tick();
    #2 rst_n = 1'b1;
    repeat (6) tick();
    check_model("rstmid.stale");
    bus.rx_ready = 1'b0;
    tick();

`ifdef UART_RX_CTRL_ECHO_EN
    begin
      int tx0;
      tx0 = tx_cnt;
      send(8'h33, 0);
      check("echo.pulses", 32'(tx_cnt - tx0), 32'd1);
      check("echo.data", 32'(tx_last), 32'h33);
      tx_busy = 1'b1;
      send(8'h34, 0);
      tx_busy = 1'b0;
      check("echo.busy_skip", 32'(tx_cnt - tx0), 32'd1);
    end
`else
    send(8'h33, 0);
    send(8'h34, 0);
`endif
    check_model("post_rst");
    drain("post_rst.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
